ddr4_reset_n_tx_ctrl: RTL
=========================

# ddr4_reset_n_tx_ctrl

Fabric-side driver for the DDR4 RESET_N output IOD in the DDR PHY block. It runs the JEDEC reset/power-up timing sequence as 4-bit serialised TX/OE words on FAB_CLK. It also acts as initiator for the IOD's dynamic output delay line, issuing MOVE/DIRECTION/LOAD commands and tracking the tap count. It sits between the training/init controller and the RESET_N PF_IOD instance.

## Interface
Parameters:
- RST_LOW_CYCLES, 40000, FAB_CLK cycles RESET_N is held low after INIT_START (200 us at 200 MHz); legal range 1..2^24-1.
- POST_RST_CYCLES, 100000, cycles from RESET_N release to INIT_DONE (500 us); legal range 1..2^24-1.
- TAP_INIT, 1, tap count after reset or LOAD; must match the IOD TX_DELAY_VAL.
- MAX_TAP, 127, highest legal tap index.

Ports:
- FAB_CLK  in  1  single clock for all logic.
- ARST  in  1  asynchronous, active-high reset.
- INIT_START  in  1  single-cycle pulse that starts or restarts the reset sequence.
- INIT_DONE  out  1  high when the post-reset wait is complete.
- TX_DATA_0  out  4  serialised RESET_N level to the IOD; all bits are equal.
- OE_DATA_0  out  4  output-enable word to the IOD.
- TAP_REQ  in  1  single-cycle request for one tap move.
- TAP_DIR  in  1  direction of the move: 1 = increment, 0 = decrement; sampled together with TAP_REQ.
- TAP_LOAD  in  1  single-cycle request to reload the delay line to TAP_INIT.
- TAP_BUSY  out  1  tap engine is not idle.
- TAP_ACK  out  1  single-cycle completion pulse for a move or load.
- TAP_ERR  out  1  qualified by TAP_ACK; the move was rejected or went out of range.
- TAP_COUNT  out  8  current tap index.
- DELAY_LINE_MOVE_0  out  1  move strobe to the IOD.
- DELAY_LINE_DIRECTION_0  out  1  direction to the IOD.
- DELAY_LINE_LOAD_0  out  1  load strobe to the IOD.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  out-of-range flag from the IOD.

## Operation
Reset FSM (states HOLD, ASSERT, RELEASE, DONE):
- While ARST is high, and after it releases:
  - state = HOLD;
  - TX_DATA_0 = 4'b0000 (DRAM held in reset);
  - OE_DATA_0 = 4'b1111;
  - INIT_DONE = 0.
- HOLD: waits for INIT_START, then goes to ASSERT and clears the 24-bit counter.
- ASSERT: TX_DATA_0 = 0000. Once the counter reaches RST_LOW_CYCLES-1, the FSM goes to RELEASE, clears the counter and sets TX_DATA_0 to 1111.
- RELEASE: TX_DATA_0 = 1111. Once the counter reaches POST_RST_CYCLES-1, the FSM goes to DONE.
- DONE: INIT_DONE = 1. INIT_START goes to ASSERT, which drops TX_DATA_0 and INIT_DONE on the next edge.
- INIT_START in ASSERT or RELEASE is ignored.
- OE_DATA_0 is 4'b1111 in every state.

Tap engine (states T_IDLE, T_SETUP, T_MOVE, T_SETTLE, T_LOAD, T_ACK), independent of the reset FSM:
- T_IDLE, TAP_LOAD: goes to T_LOAD. TAP_LOAD has priority over a simultaneous TAP_REQ, and that TAP_REQ is dropped.
- T_IDLE, TAP_REQ at a boundary (TAP_DIR = 1 with TAP_COUNT = MAX_TAP, or TAP_DIR = 0 with TAP_COUNT = 0): goes to T_ACK with error = 1. No MOVE is issued.
- T_IDLE, any other TAP_REQ: latches TAP_DIR into DELAY_LINE_DIRECTION_0 and goes to T_SETUP.
- T_SETUP (1 cycle): goes to T_MOVE.
- T_MOVE (1 cycle): DELAY_LINE_MOVE_0 = 1.
- T_SETTLE (3 cycles): samples DELAY_LINE_OUT_OF_RANGE_0 on the last cycle.
  - If it is 1: error = 1 and TAP_COUNT is unchanged.
  - If it is 0: TAP_COUNT moves by ±1.
  - Either way the engine goes to T_ACK.
- T_LOAD (1 cycle): DELAY_LINE_LOAD_0 = 1 and TAP_COUNT = TAP_INIT. Goes to T_ACK with error = 0.
- T_ACK (1 cycle): TAP_ACK = 1 and TAP_ERR = error. Returns to T_IDLE.
- TAP_BUSY = 1 in every state except T_IDLE. TAP_REQ or TAP_LOAD arriving while busy is dropped silently.
- DELAY_LINE_DIRECTION_0 stays stable from T_SETUP until the engine returns to T_IDLE.
- Reset values: all strobes 0, TAP_ACK 0, TAP_ERR 0, TAP_BUSY 0, TAP_COUNT = TAP_INIT, DELAY_LINE_DIRECTION_0 = 0.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- With INIT_START sampled at edge 0:
  - TX_DATA_0 = 0000 from edge 1;
  - TX_DATA_0 = 1111 at edge 1+RST_LOW_CYCLES;
  - INIT_DONE = 1 at edge 1+RST_LOW_CYCLES+POST_RST_CYCLES.
- Tap move with TAP_REQ at edge 0:
  - DELAY_LINE_DIRECTION_0 valid at edge 1;
  - MOVE high for exactly 1 cycle, starting at edge 2;
  - OUT_OF_RANGE sampled at edge 5;
  - TAP_ACK high at edge 6;
  - TAP_COUNT updated at edge 6;
  - TAP_BUSY low at edge 7;
  - the next request is accepted at edge 7.
- Load with TAP_LOAD at edge 0: LOAD high at edge 1, TAP_ACK at edge 2.
- Boundary reject with TAP_REQ at edge 0: TAP_ACK with TAP_ERR at edge 1. No strobe is issued.
- ARST in mid-operation: both FSMs return to their reset values immediately (asynchronously). Any in-flight MOVE or LOAD strobe is cut short. TAP_COUNT returns to TAP_INIT.

## Test plan
Benches use RST_LOW_CYCLES=8, POST_RST_CYCLES=5, TAP_INIT=1, MAX_TAP=3.
- ARST release, no INIT_START for 50 cycles -> TX_DATA_0 = 0000, OE_DATA_0 = 1111, INIT_DONE = 0 throughout.
- INIT_START at edge 0 -> TX_DATA_0 goes 1111 at edge 9, INIT_DONE = 1 at edge 14. A second INIT_START at edge 5 is ignored.
- INIT_START while in DONE -> TX_DATA_0 = 0000 and INIT_DONE = 0 on the next edge, then the full sequence repeats.
- Three increment requests from TAP_COUNT = 1:
  - first two: 2, then 3, each acked with TAP_ERR = 0 and one 1-cycle MOVE with DIRECTION = 1;
  - third: immediate ACK with TAP_ERR = 1, no MOVE.
- Decrement request with OUT_OF_RANGE forced to 1 -> TAP_ERR = 1, TAP_COUNT unchanged. Then TAP_LOAD together with TAP_REQ -> LOAD pulse only, TAP_COUNT = 1, the REQ is dropped.
- ARST asserted in the cycle MOVE is high -> MOVE low immediately, TAP_COUNT = 1, reset FSM back in HOLD.

Source files
------------

// File: rtl/ddr4_reset_n_tx_ctrl_if.sv
// ddr4_reset_n_tx_ctrl_if
//   Bundles everything the RESET_N fabric driver exchanges with the
//   training/init controller and with the RESET_N PF_IOD.
//   Ports (slave = the driver itself, master = its environment):
//     INIT_START / INIT_DONE            reset sequence start pulse / done level
//     TX_DATA_0 / OE_DATA_0             4-bit serialised RESET_N level and OE
//     TAP_REQ / TAP_DIR / TAP_LOAD      tap move / reload request pulses
//     TAP_BUSY / TAP_ACK / TAP_ERR      tap engine status and completion
//     TAP_COUNT                         current tap index
//     DELAY_LINE_*_0                    IOD delay-line command/status
//     rst_state / tap_state             FSM state visibility for checkers
//
// Handshake: TAP_REQ and TAP_LOAD are single-cycle pulses that act as
// "valid"; the engine is "ready" exactly when TAP_BUSY is low. A pulse seen
// while TAP_BUSY is high is dropped without any response. Each accepted
// pulse gets exactly one TAP_ACK cycle, with TAP_ERR valid only in that cycle.
interface ddr4_reset_n_tx_ctrl_if;
    logic       INIT_START;
    logic       INIT_DONE;
    logic [3:0] TX_DATA_0;
    logic [3:0] OE_DATA_0;
    logic       TAP_REQ;
    logic       TAP_DIR;
    logic       TAP_LOAD;
    logic       TAP_BUSY;
    logic       TAP_ACK;
    logic       TAP_ERR;
    logic [7:0] TAP_COUNT;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_OUT_OF_RANGE_0;
    logic [1:0] rst_state;
    logic [2:0] tap_state;

    modport slave (
        input  INIT_START, TAP_REQ, TAP_DIR, TAP_LOAD, DELAY_LINE_OUT_OF_RANGE_0,
        output INIT_DONE, TX_DATA_0, OE_DATA_0, TAP_BUSY, TAP_ACK, TAP_ERR,
               TAP_COUNT, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
               DELAY_LINE_LOAD_0, rst_state, tap_state
    );

    modport master (
        output INIT_START, TAP_REQ, TAP_DIR, TAP_LOAD, DELAY_LINE_OUT_OF_RANGE_0,
        input  INIT_DONE, TX_DATA_0, OE_DATA_0, TAP_BUSY, TAP_ACK, TAP_ERR,
               TAP_COUNT, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
               DELAY_LINE_LOAD_0, rst_state, tap_state
    );
endinterface

// File: rtl/ddr4_reset_n_tx_ctrl.sv
// ddr4_reset_n_tx_ctrl
//   Fabric-side driver for the DDR4 RESET_N output IOD. Runs the power-up
//   reset timing (hold low, release, wait) as 4-bit TX/OE words, and drives
//   the IOD dynamic delay line with MOVE/DIRECTION/LOAD while tracking the
//   tap index.
//   Ports:
//     FAB_CLK  single clock
//     ARST     asynchronous active-high reset
//     bus      ddr4_reset_n_tx_ctrl_if.slave (all functional signals)
//   Every output is a flop (or a constant); no input reaches an output
//   without passing through a register.
module ddr4_reset_n_tx_ctrl #(
    parameter int unsigned RST_LOW_CYCLES  = 40000,
    parameter int unsigned POST_RST_CYCLES = 100000,
    parameter int unsigned TAP_INIT        = 1,
    parameter int unsigned MAX_TAP         = 127
) (
    input  logic                   FAB_CLK,
    input  logic                   ARST,
    ddr4_reset_n_tx_ctrl_if.slave  bus
);
    localparam logic [23:0] RST_LOW_LAST  = 24'(RST_LOW_CYCLES - 1);
    localparam logic [23:0] POST_RST_LAST = 24'(POST_RST_CYCLES - 1);
    localparam logic [7:0]  TAP_INIT_VAL  = 8'(TAP_INIT);
    localparam logic [7:0]  MAX_TAP_VAL   = 8'(MAX_TAP);

    // ------------------------------------------------------------ reset FSM
    typedef enum logic [1:0] {HOLD, ASSERT, RELEASE, DONE} rst_state_t;

    rst_state_t  rst_state, rst_next;
    logic [23:0] rst_cnt, rst_cnt_next;
    logic        tx_high, init_done;

    always_comb begin
        rst_next     = rst_state;
        rst_cnt_next = rst_cnt + 24'd1;
        case (rst_state)
            HOLD: begin
                rst_cnt_next = '0;
                if (bus.INIT_START) rst_next = ASSERT;
            end
            ASSERT: begin
                if (rst_cnt == RST_LOW_LAST) begin
                    rst_next     = RELEASE;
                    rst_cnt_next = '0;
                end
            end
            RELEASE: begin
                if (rst_cnt == POST_RST_LAST) begin
                    rst_next     = DONE;
                    rst_cnt_next = '0;
                end
            end
            DONE: begin
                rst_cnt_next = '0;
                if (bus.INIT_START) rst_next = ASSERT;
            end
            default: begin
                rst_next     = HOLD;
                rst_cnt_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe instead of lagging one cycle behind it.
    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            rst_state <= HOLD;
            rst_cnt   <= '0;
            tx_high   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            rst_state <= rst_next;
            rst_cnt   <= rst_cnt_next;
            tx_high   <= (rst_next == RELEASE) || (rst_next == DONE);
            init_done <= (rst_next == DONE);
        end
    end

    // ----------------------------------------------------------- tap engine
    typedef enum logic [2:0] {T_IDLE, T_SETUP, T_MOVE, T_SETTLE, T_LOAD, T_ACK} tap_state_t;

    tap_state_t tap_state, tap_next;
    logic [1:0] settle_cnt, settle_next;
    logic       err_flag, err_next;
    logic [7:0] tap_count, count_next;
    logic       move_dir, dir_next;
    logic       at_boundary;
    logic       move_q, load_q, ack_q, err_q, busy_q;

    assign at_boundary = bus.TAP_DIR ? (tap_count >= MAX_TAP_VAL) : (tap_count == 8'd0);

    always_comb begin
        tap_next    = tap_state;
        settle_next = settle_cnt;
        err_next    = err_flag;
        count_next  = tap_count;
        dir_next    = move_dir;
        case (tap_state)
            T_IDLE: begin
                // LOAD wins over a simultaneous REQ; the REQ is simply lost.
                if (bus.TAP_LOAD) begin
                    tap_next   = T_LOAD;
                    count_next = TAP_INIT_VAL;
                    err_next   = 1'b0;
                end else if (bus.TAP_REQ) begin
                    if (at_boundary) begin
                        tap_next = T_ACK;
                        err_next = 1'b1;
                    end else begin
                        tap_next = T_SETUP;
                        dir_next = bus.TAP_DIR;
                        err_next = 1'b0;
                    end
                end
            end
            T_SETUP: tap_next = T_MOVE;
            T_MOVE: begin
                tap_next    = T_SETTLE;
                settle_next = 2'd0;
            end
            T_SETTLE: begin
                // The IOD flag is only trusted on the third settle cycle.
                if (settle_cnt == 2'd2) begin
                    tap_next = T_ACK;
                    if (bus.DELAY_LINE_OUT_OF_RANGE_0) begin
                        err_next = 1'b1;
                    end else begin
                        err_next   = 1'b0;
                        count_next = move_dir ? tap_count + 8'd1 : tap_count - 8'd1;
                    end
                end else begin
                    settle_next = settle_cnt + 2'd1;
                end
            end
            T_LOAD:  tap_next = T_ACK;
            T_ACK:   tap_next = T_IDLE;
            default: tap_next = T_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            tap_state  <= T_IDLE;
            settle_cnt <= '0;
            err_flag   <= 1'b0;
            tap_count  <= TAP_INIT_VAL;
            move_dir   <= 1'b0;
            move_q     <= 1'b0;
            load_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tap_state  <= tap_next;
            settle_cnt <= settle_next;
            err_flag   <= err_next;
            tap_count  <= count_next;
            move_dir   <= dir_next;
            move_q     <= (tap_next == T_MOVE);
            load_q     <= (tap_next == T_LOAD);
            ack_q      <= (tap_next == T_ACK);
            err_q      <= (tap_next == T_ACK) && err_next;
            busy_q     <= (tap_next != T_IDLE);
        end
    end

    // ------------------------------------------------------------- outputs
    assign bus.TX_DATA_0              = {4{tx_high}};
    assign bus.OE_DATA_0              = 4'b1111;
    assign bus.INIT_DONE              = init_done;
    assign bus.TAP_BUSY               = busy_q;
    assign bus.TAP_ACK                = ack_q;
    assign bus.TAP_ERR                = err_q;
    assign bus.TAP_COUNT              = tap_count;
    assign bus.DELAY_LINE_MOVE_0      = move_q;
    assign bus.DELAY_LINE_DIRECTION_0 = move_dir;
    assign bus.DELAY_LINE_LOAD_0      = load_q;
    assign bus.rst_state              = rst_state;
    assign bus.tap_state              = tap_state;
endmodule
